motion_diff_threshold: RTL
==========================

// Module: motion_diff_threshold
// PURPOSE
//  Streaming background-subtraction stage inside motion_detect_top, fed by two grayscale FIFOs.
//  - Input FIFO carries the current frame; base FIFO carries the background frame.
//  - Per pixel: computes |cur - base|, compares it with a threshold, and writes an 8-bit
//    motion mask (0xFF motion / 0x00 still) to the output FIFO.
//  - The downstream highlight stage merges this mask with the held input pixels.
// PARAMETERS
//  WIDTH      768  pixels per line
//  HEIGHT     576  lines per frame
//  CNT_BITS   20   width of pixel index / motion count (must satisfy >= clog2(WIDTH*HEIGHT+1))
// PORTS
//  clock         in   1   single system clock, all logic posedge
//  reset         in   1   synchronous, active-high
//  threshold     in   8   motion threshold, sampled at frame start
//  in_rd_en      out  1   pop current-frame FIFO (FWFT: in_dout valid while !in_empty)
//  in_empty      in   1   current-frame FIFO empty
//  in_dout       in   8   current grayscale pixel
//  base_rd_en    out  1   pop base FIFO
//  base_empty    in   1   base FIFO empty
//  base_dout     in   8   base grayscale pixel
//  out_wr_en     out  1   push mask FIFO
//  out_full      in   1   mask FIFO full
//  out_din       out  8   mask pixel, 0xFF or 0x00
//  frame_done    out  1   1-cycle pulse on the write of a frame's last pixel
//  motion_count  out  CNT_BITS  motion pixels in last completed frame (macro-gated)
// BEHAVIOUR
//  Reset values:
//  - in_rd_en=0, base_rd_en=0, out_wr_en=0, out_din=0, frame_done=0, motion_count=0.
//  - Pixel index=0; pipeline valid=0; threshold latch=0.
//  Pipeline: one output register (valid, mask, last).
//  - can_accept = !valid | !out_full.
//  - accept = !in_empty & !base_empty & can_accept.
//  - in_rd_en = base_rd_en = accept. Both FIFOs always pop together, never one alone.
//  - On accept: diff = (cur>=base) ? cur-base : base-cur, 8-bit unsigned, no overflow.
//    mask = (diff > thr_eff) ? 8'hFF : 8'h00 (strict compare).
//  - Register loads mask, valid<=1, last<=(index==WIDTH*HEIGHT-1).
//  - out_wr_en = valid & !out_full (combinational from register). out_din = registered mask.
//  - Write with no accept clears valid. Accept in the same cycle as a write reloads the register.
//  - Throughput: 1 pixel/cycle when FIFOs are non-empty and not full.
//    Latency: 1 cycle from accept to out_wr_en.
//  Threshold:
//  - thr_eff = threshold port when index==0; latched value otherwise.
//  - Latch loads on accept at index==0, so threshold is frozen for the whole frame.
//  Pixel index:
//  - Increments on accept; wraps WIDTH*HEIGHT-1 -> 0 so the next frame starts cleanly.
//  frame_done: asserted in the cycle out_wr_en=1 with last=1.
//  Boundaries:
//  - out_full while valid: hold register and outputs stable; no accept; no pixel lost or duplicated.
//  - Only one input FIFO non-empty: no pop, no state change.
//  - Reset mid-frame: pipeline and index cleared next edge; FIFO contents are not flushed here.
//    In-flight register contents are dropped.
// CONFIGURATION
//  MOTION_DIFF_COUNT_EN defined:
//  - Running counter +1 per written mask==0xFF.
//  - On frame_done, motion_count <= running count (including the last pixel), then running
//    count clears.
//  - motion_count holds until the next frame_done.
//  Undefined: no counter logic; motion_count port tied to 0.
// TESTING
//  1 WIDTH=4,HEIGHT=2, thr=10; cur=50,base=40 (diff 10) -> 0x00; cur=40,base=51 (11) -> 0xFF.
//  2 cur=0,base=255 and cur=255,base=0, thr=254 -> 0xFF both; thr=255 -> 0x00 both.
//  3 out_full held 5 cycles, FIFOs full -> no rd_en; out_din stable; 8 masks out in order, no loss.
//  4 threshold 10->200 at pixel 3 -> frame uses 10 throughout; next frame pixel 0 onward uses 200.
//  5 8-pixel frame, 3 diffs over thr -> frame_done single pulse with 8th write;
//    motion_count=3 with MOTION_DIFF_COUNT_EN, 0 without.
//  6 reset asserted after pixel 5 -> all outputs reset next edge; next accepted pixel is index 0
//    and uses the port threshold.

Source files
------------

// File: rtl/motion_diff_threshold.sv
// Streaming background-subtraction stage: |cur - base| against a per-frame threshold -> 0xFF/0x00 mask.
// Define MOTION_DIFF_COUNT_EN to enable the per-frame motion pixel counter on motion_count.
module motion_diff_threshold #(
    parameter int unsigned WIDTH    = 768,
    parameter int unsigned HEIGHT   = 576,
    parameter int unsigned CNT_BITS = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          threshold,
    output logic                in_rd_en,
    input  logic                in_empty,
    input  logic [7:0]          in_dout,
    output logic                base_rd_en,
    input  logic                base_empty,
    input  logic [7:0]          base_dout,
    output logic                out_wr_en,
    input  logic                out_full,
    output logic [7:0]          out_din,
    output logic                frame_done,
    output logic [CNT_BITS-1:0] motion_count
);

    localparam int unsigned         NPIX     = WIDTH * HEIGHT;
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NPIX - 1);

    logic                valid_q, valid_d;
    logic [7:0]          mask_q, mask_d;
    logic                last_q, last_d;
    logic [CNT_BITS-1:0] idx_q, idx_d;
    logic [7:0]          thr_q, thr_d;

    logic                pix_accept;
    logic                pix_push;
    logic [7:0]          thr_eff;
    logic [7:0]          diff;

    // Handshake, absolute difference and output-register next state.
    // Reset gates both handshakes so nothing is popped or pushed while the stage is cleared.
    always_comb begin
        pix_push   = valid_q & ~out_full & ~reset;
        pix_accept = ~in_empty & ~base_empty & (~valid_q | ~out_full) & ~reset;
        thr_eff    = (idx_q == '0) ? threshold : thr_q;
        diff       = (in_dout >= base_dout) ? (in_dout - base_dout) : (base_dout - in_dout);

        valid_d = valid_q;
        mask_d  = mask_q;
        last_d  = last_q;
        idx_d   = idx_q;
        thr_d   = thr_q;

        if (pix_push) begin
            valid_d = 1'b0;
        end
        if (pix_accept) begin
            valid_d = 1'b1;
            mask_d  = (diff > thr_eff) ? 8'hFF : 8'h00;
            last_d  = (idx_q == LAST_IDX);
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + CNT_BITS'(1);
            if (idx_q == '0) begin
                thr_d = threshold;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            mask_q  <= 8'h00;
            last_q  <= 1'b0;
            idx_q   <= '0;
            thr_q   <= 8'h00;
        end else begin
            valid_q <= valid_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            thr_q   <= thr_d;
        end
    end

    assign in_rd_en   = pix_accept;
    assign base_rd_en = pix_accept;
    assign out_wr_en  = pix_push;
    assign out_din    = mask_q;
    assign frame_done = pix_push & last_q;

`ifdef MOTION_DIFF_COUNT_EN
    logic [CNT_BITS-1:0] run_q, run_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] run_inc;

    // Running count includes the frame's last pixel before it is published.
    always_comb begin
        run_inc = run_q + CNT_BITS'(mask_q == 8'hFF);
        run_d   = run_q;
        cnt_d   = cnt_q;
        if (pix_push) begin
            if (last_q) begin
                cnt_d = run_inc;
                run_d = '0;
            end else begin
                run_d = run_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q <= '0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    assign motion_count = cnt_q;
`else
    assign motion_count = '0;
`endif

endmodule
